// File: rtl/alu_exec_pkg.sv
// Shared ALU control codes, FSM state encoding and the single-cycle ALU function.
// Imported by alu_exec and by the ALU controller that generates ALUCtrl codes.
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // MUL is iterative and produced elsewhere, so it falls into the zero default here.
  function automatic logic [31:0] alu_eval(input logic [3:0]  ctrl,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (ctrl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the issuing stage and alu_exec.
interface alu_exec_if;
  import alu_exec_pkg::*;

  logic        start_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;

  modport master (
    output start_i, ALUCtrl_i, src1_i, src2_i,
    input  ready_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, src1_i, src2_i,
    output ready_o, done_o, result_o, zero_o
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial-product step per cycle, down-counter terminal count.
// product is the accumulator value after the current step, so the caller can register it
// on the same edge that performs the final step.
module alu_mul_seq #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        last
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [CW-1:0] cnt_q;

  assign product = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign last    = (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= 32'd0;
      cnt_q    <= CW'(MUL_CYCLES);
    end else if (step && (cnt_q != '0)) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle logic/arith ops, iterative MUL via alu_mul_seq.
//   state   | meaning
//   ST_IDLE | ready, accepts start_i
//   ST_MUL  | multiplier stepping, start_i ignored
//   ST_DONE | done_o pulse, result_o/zero_o valid
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input logic        clk_i,
  input logic        rst_i,
  alu_exec_if.slave  bus
);

  state_t      state_q, state_d;
  logic [31:0] result_q;
  logic        zero_q;
  logic        accept;
  logic        is_mul;
  logic        mul_step;
  logic        mul_last;
  logic [31:0] mul_product;
  logic        result_load;
  logic [31:0] result_d;

  assign accept   = (state_q == ST_IDLE) && bus.start_i;
  assign is_mul   = (bus.ALUCtrl_i == ALU_MUL);
  assign mul_step = (state_q == ST_MUL);

  alu_mul_seq #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (accept && is_mul),
    .step    (mul_step),
    .a       (bus.src1_i),
    .b       (bus.src2_i),
    .product (mul_product),
    .last    (mul_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_last)    state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result is captured only on the edge that enters ST_DONE.
  assign result_load = (accept && !is_mul) || (mul_step && mul_last);
  assign result_d    = mul_step ? mul_product
                                : alu_eval(bus.ALUCtrl_i, bus.src1_i, bus.src2_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (result_load) begin
        result_q <= result_d;
        zero_q   <= (result_d == 32'd0);
      end
    end
  end

  assign bus.ready_o  = (state_q == ST_IDLE);
  assign bus.done_o   = (state_q == ST_DONE);
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: expected results queued at issue, checked on done_o.
module tb_alu_exec;

  localparam int MUL_CYCLES = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] sb_res[$];
  int          sb_cyc[$];
  logic [31:0] last_res = 32'd0;

  alu_exec_if bus ();

  alu_exec #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] c);
    return (c == 4'b1000) ? MUL_CYCLES + 1 : 1;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      if (sb_res.size() == 0) begin
        check("spurious_done", {31'd0, bus.done_o}, 32'd0);
      end else begin
        logic [31:0] er;
        int          ec;
        er = sb_res.pop_front();
        ec = sb_cyc.pop_front();
        last_res = er;
        check("result", bus.result_o, er);
        check("zero", {31'd0, bus.zero_o}, {31'd0, (er == 32'd0)});
        check("done_cycle", cyc, ec);
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = c;
    bus.src1_i    = a;
    bus.src2_i    = b;
  endtask

  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready_o !== 1'b1) check("ready_timeout", {31'd0, bus.ready_o}, 32'd1);
    drive(c, a, b);
    sb_res.push_back(model(c, a, b));
    sb_cyc.push_back(cyc + latency(c));
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_res.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb_res.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] codes [8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0011, 4'b1111};
    bus.start_i = 1'b0; bus.ALUCtrl_i = 4'd0; bus.src1_i = 32'd0; bus.src2_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready",  {31'd0, bus.ready_o}, 32'd1);
    check("rst_done",   {31'd0, bus.done_o},  32'd0);
    check("rst_result", bus.result_o,         32'd0);
    check("rst_zero",   {31'd0, bus.zero_o},  32'd1);

    do_op(4'b0010, 32'd7, 32'd5);
    do_op(4'b0110, 32'd9, 32'd9);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1);
    do_op(4'b0111, 32'h8000_0000, 32'd1);
    do_op(4'b0111, 32'd1, 32'h8000_0000);
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd2);
    do_op(4'b1000, 32'h0001_0001, 32'd3);
    do_op(4'b1000, 32'hFFFF_FFFF, 32'd2);
    drain();

    // result must hold through idle
    repeat (3) @(negedge clk);
    check("idle_hold", bus.result_o, last_res);

    // busy rejection: ADD 1+1 during MUL must vanish; operands changed after acceptance
    do_op(4'b1000, 32'd1234, 32'd5678);
    repeat (5) @(negedge clk);
    check("busy_ready", {31'd0, bus.ready_o}, 32'd0);
    drive(4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    bus.start_i = 1'b0;
    drain();
    check("busy_single", sb_res.size(), 32'd0);

    // reset at cycle 10 of MUL, start held on the same edge
    do_op(4'b1000, 32'd77, 32'd99);
    repeat (9) @(negedge clk);
    sb_res.delete();
    sb_cyc.delete();
    rst = 1'b1;
    drive(4'b0010, 32'd3, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    check("mrst_ready",  {31'd0, bus.ready_o}, 32'd1);
    check("mrst_done",   {31'd0, bus.done_o},  32'd0);
    check("mrst_result", bus.result_o,         32'd0);
    check("mrst_zero",   {31'd0, bus.zero_o},  32'd1);
    repeat (40) @(negedge clk);
    check("mrst_quiet", bus.result_o, 32'd0);

    // back-to-back with start held high: one acceptance every 2 cycles
    begin
      logic [3:0]  bc [3];
      logic [31:0] ba [3];
      logic [31:0] bb [3];
      bc = '{4'b0000, 4'b0001, 4'b0011};
      ba = '{32'h0000_F0F0, 32'h0000_F0F0, 32'h1234_5678};
      bb = '{32'h0000_FF00, 32'h0000_0F0F, 32'h0000_0001};
      for (int i = 0; i < 3; i++) begin
        drive(bc[i], ba[i], bb[i]);
        sb_res.push_back(model(bc[i], ba[i], bb[i]));
        sb_cyc.push_back(cyc + 1);
        @(negedge clk);
        bus.src1_i = 32'hDEAD_BEEF;
        @(negedge clk);
      end
      bus.start_i = 1'b0;
      drain();
    end

    for (int i = 0; i < 10; i++) begin
      do_op(codes[$urandom_range(0, 7)], $urandom, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
